// File: rtl/spi_slave_io_pkg.sv
// Shared definitions for the spi_slave_io IO peripheral: register offsets,
// CTRL/STAT bit positions and the frame FSM state encoding.
package spi_slave_io_pkg;

  localparam logic [7:0] OFS_DATA = 8'd0;
  localparam logic [7:0] OFS_STAT = 8'd1;
  localparam logic [7:0] OFS_CTRL = 8'd2;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_CPHA   = 1;
  localparam int CTRL_CPOL   = 2;
  localparam int CTRL_IE_RX  = 3;
  localparam int CTRL_IE_ERR = 4;

  localparam int STAT_RXFULL   = 0;
  localparam int STAT_TXEMPTY  = 1;
  localparam int STAT_SS       = 2;
  localparam int STAT_UNDERRUN = 6;
  localparam int STAT_OVERRUN  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } spi_state_t;

endpackage

// File: rtl/spi_slave_io_rx_fifo.sv
// Synchronous RX byte FIFO for spi_slave_io; only built when SPI_SLAVE_RXFIFO_EN
// is defined. Pop and push in the same cycle are both honoured, even when full.
`ifdef SPI_SLAVE_RXFIFO_EN
module spi_rx_fifo #(
  parameter int AW = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int DEPTH = 1 << AW;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH[AW:0]);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule
`endif

// File: rtl/spi_slave_io.sv
// SPI slave in light8080 IO space: DATA/STAT/CTRL registers, pin synchronizers,
// frame FSM and shifters. Define SPI_SLAVE_RXFIFO_EN for a multi-entry RX FIFO.
module spi_slave_io
  import spi_slave_io_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'h90,
  parameter logic [7:0] TX_IDLE   = 8'hFF
`ifdef SPI_SLAVE_RXFIFO_EN
  , parameter int       FIFO_AW   = 2
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] bus_addr,
  input  logic       bus_io,
  input  logic       bus_rd,
  input  logic       bus_wr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       irq,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe
);

  // Bus valid/ready: an IO access is a single-cycle request qualified by bus_io;
  // the peripheral is always ready, read data appears the cycle after the request.

  logic [2:0] sck_s, ss_s, mosi_s;
  logic       sck_rise, sck_fall, ss_fall, ss_n_sync;
  logic       sample_edge, shift_edge, abort;

  spi_state_t state;
  logic [2:0] bitcnt;
  logic [7:0] shift_rx, shift_tx;

  logic [4:0] ctrl;
  logic [7:0] tx_hold;
  logic       txempty, underrun, overrun;
  logic       rd_q, rd_first, wr;
  logic       hit_data, hit_stat, hit_ctrl;
  logic       rx_push, rx_pop, rxfull, ovr_evt, load_now;
  logic [7:0] rx_head, stat_val, rd_mux;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_s  <= 3'b000;
      ss_s   <= 3'b111;
      mosi_s <= 3'b000;
    end else begin
      sck_s  <= {sck_s[1:0], spi_sck};
      ss_s   <= {ss_s[1:0], spi_ss_n};
      mosi_s <= {mosi_s[1:0], spi_mosi};
    end
  end

  assign ss_n_sync   = ss_s[1];
  assign ss_fall     = ss_s[2] & ~ss_s[1];
  assign sck_rise    = sck_s[1] & ~sck_s[2];
  assign sck_fall    = ~sck_s[1] & sck_s[2];
  assign sample_edge = (ctrl[CTRL_CPOL] == ctrl[CTRL_CPHA]) ? sck_rise : sck_fall;
  assign shift_edge  = (ctrl[CTRL_CPOL] == ctrl[CTRL_CPHA]) ? sck_fall : sck_rise;
  assign abort       = ss_n_sync | ~ctrl[CTRL_EN];

  assign load_now = (state == ST_LOAD) || (state == ST_DONE);
  assign rx_push  = (state == ST_DONE);

  // A shift edge seen with bitcnt==0 is the one that would clobber a freshly
  // loaded bit7: the leading edge for cpha=1, the post-byte trailing edge for cpha=0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      bitcnt   <= 3'd0;
      shift_rx <= 8'h00;
      shift_tx <= TX_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          bitcnt <= 3'd0;
          if (ss_fall && ctrl[CTRL_EN]) state <= ST_LOAD;
        end
        ST_LOAD: begin
          shift_tx <= txempty ? TX_IDLE : tx_hold;
          bitcnt   <= 3'd0;
          state    <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (abort) begin
            state    <= ST_IDLE;
            bitcnt   <= 3'd0;
            shift_tx <= TX_IDLE;
          end else if (sample_edge) begin
            shift_rx <= {shift_rx[6:0], mosi_s[1]};
            bitcnt   <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= ST_DONE;
          end else if (shift_edge && bitcnt != 3'd0) begin
            shift_tx <= {shift_tx[6:0], 1'b1};
          end
        end
        ST_DONE: begin
          shift_tx <= txempty ? TX_IDLE : tx_hold;
          state    <= abort ? ST_IDLE : ST_SHIFT;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign spi_miso    = shift_tx[7];
  assign spi_miso_oe = ~ss_n_sync & ctrl[CTRL_EN];

  assign hit_data = bus_io && (bus_addr == BASE_ADDR + OFS_DATA);
  assign hit_stat = bus_io && (bus_addr == BASE_ADDR + OFS_STAT);
  assign hit_ctrl = bus_io && (bus_addr == BASE_ADDR + OFS_CTRL);
  assign wr       = bus_io & bus_wr;
  assign rd_first = bus_io & bus_rd & ~rd_q;
  assign rx_pop   = rd_first & hit_data;

`ifdef SPI_SLAVE_RXFIFO_EN
  logic fifo_full, fifo_empty;

  spi_rx_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (rx_push),
    .push_data (shift_rx),
    .pop       (rx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (rx_head)
  );

  assign rxfull  = ~fifo_empty;
  assign ovr_evt = rx_push & fifo_full & ~rx_pop;
`else
  logic       rx_valid;
  logic [7:0] rx_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_valid <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      if (rx_pop) rx_valid <= 1'b0;
      if (rx_push && (!rx_valid || rx_pop)) begin
        rx_data  <= shift_rx;
        rx_valid <= 1'b1;
      end
    end
  end

  assign rx_head = rx_data;
  assign rxfull  = rx_valid;
  assign ovr_evt = rx_push & rx_valid & ~rx_pop;
`endif

  always_comb begin
    stat_val                = 8'h00;
    stat_val[STAT_RXFULL]   = rxfull;
    stat_val[STAT_TXEMPTY]  = txempty;
    stat_val[STAT_SS]       = ~ss_n_sync;
    stat_val[STAT_UNDERRUN] = underrun;
    stat_val[STAT_OVERRUN]  = overrun;
  end

  always_comb begin
    rd_mux = 8'h00;
    if (hit_data)      rd_mux = rx_head;
    else if (hit_stat) rd_mux = stat_val;
    else if (hit_ctrl) rd_mux = {3'b000, ctrl};
  end

  // Flag sets win over a same-cycle W1C; a CPU TX write wins over the shifter load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ctrl      <= 5'd0;
      tx_hold   <= 8'h00;
      txempty   <= 1'b1;
      underrun  <= 1'b0;
      overrun   <= 1'b0;
      rd_q      <= 1'b0;
      bus_rdata <= 8'h00;
      irq       <= 1'b0;
    end else begin
      rd_q <= bus_io & bus_rd;
      if (wr && hit_ctrl) ctrl <= bus_wdata[4:0];
      if (wr && hit_stat) begin
        if (bus_wdata[STAT_OVERRUN])  overrun  <= 1'b0;
        if (bus_wdata[STAT_UNDERRUN]) underrun <= 1'b0;
      end
      if (ovr_evt) overrun <= 1'b1;
      if (load_now && txempty) underrun <= 1'b1;
      if (load_now) txempty <= 1'b1;
      if (wr && hit_data) begin
        tx_hold <= bus_wdata;
        txempty <= 1'b0;
      end
      if (rd_first && (hit_data || hit_stat || hit_ctrl)) bus_rdata <= rd_mux;
      irq <= (ctrl[CTRL_IE_RX] & rxfull) | (ctrl[CTRL_IE_ERR] & (overrun | underrun));
    end
  end

endmodule

// File: tb/tb_spi_slave_io.sv
// Bench for spi_slave_io: mode table, hand-written corner sequences and random
// frames checked against a queue-based model of the register-level behaviour.
module tb_spi_slave_io;

  localparam logic [7:0] A_DATA = 8'h90;
  localparam logic [7:0] A_STAT = 8'h91;
  localparam logic [7:0] A_CTRL = 8'h92;
  localparam int         H      = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       bus_io, bus_rd, bus_wr, irq;
  logic       spi_sck, spi_ss_n, spi_mosi, spi_miso, spi_miso_oe;

  spi_slave_io dut (
    .clock(clock), .reset(reset), .bus_addr(bus_addr), .bus_io(bus_io),
    .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .irq(irq), .spi_sck(spi_sck), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int irq_rise = -1;
  logic irq_d = 1'b0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    irq_d <= irq;
    if (irq && !irq_d) irq_rise <= cyc;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Reference model: RX queue bounded by the receive depth, TX holding slot, flags.
`ifdef SPI_SLAVE_RXFIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif
  logic [7:0] m_rxq[$];
  logic       m_txfull = 1'b0;
  logic [7:0] m_txval  = 8'h00;
  logic       m_ovr = 1'b0, m_und = 1'b0;
  logic [4:0] m_ctrl = 5'd0;

  function automatic logic [7:0] m_load();
    logic [7:0] b;
    if (m_txfull) b = m_txval;
    else begin
      b = 8'hFF;
      m_und = 1'b1;
    end
    m_txfull = 1'b0;
    return b;
  endfunction

  function automatic void m_push(input logic [7:0] b);
    if (m_rxq.size() < RX_DEPTH) m_rxq.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic logic [7:0] m_stat();
    return {m_ovr, m_und, 4'b0000, ~m_txfull, m_rxq.size() != 0};
  endfunction

  function automatic logic m_irq();
    return (m_ctrl[3] && m_rxq.size() != 0) || (m_ctrl[4] && (m_ovr || m_und));
  endfunction

  // Driver tasks
  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clock);
    bus_addr = a; bus_wdata = d; bus_io = 1'b1; bus_wr = 1'b1;
    @(negedge clock);
    bus_io = 1'b0; bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, input int hold, output logic [7:0] d);
    @(negedge clock);
    bus_addr = a; bus_io = 1'b1; bus_rd = 1'b1;
    @(negedge clock);
    d = bus_rdata;
    repeat (hold - 1) @(negedge clock);
    bus_io = 1'b0; bus_rd = 1'b0;
  endtask

  task automatic cpu_ctrl(input logic [4:0] c);
    bus_write(A_CTRL, {3'b000, c});
    m_ctrl = c;
  endtask

  task automatic cpu_tx(input logic [7:0] b);
    bus_write(A_DATA, b);
    m_txfull = 1'b1; m_txval = b;
  endtask

  task automatic cpu_clear(input logic [7:0] mask);
    bus_write(A_STAT, mask);
    if (mask[7]) m_ovr = 1'b0;
    if (mask[6]) m_und = 1'b0;
  endtask

  task automatic cpu_read_data(input string name, input int hold);
    logic [7:0] d;
    bus_read(A_DATA, hold, d);
    check(name, d, m_rxq.pop_front());
  endtask

  task automatic cpu_check_stat(input string name);
    logic [7:0] d;
    bus_read(A_STAT, 1, d);
    check(name, d, m_stat());
  endtask

  task automatic check_irq(input string name);
    repeat (2) @(negedge clock);
    check(name, {7'd0, irq}, {7'd0, m_irq()});
  endtask

  // SPI master: nbytes full bytes then tail partial bits before ss_n rises.
  logic [7:0] fr_bytes[4];
  logic [7:0] miso_got[4];
  int         last_sample = 0;

  task automatic spi_frame(input logic cpol, input logic cpha, input int nbytes, input int tail);
    logic [7:0] got, exp;
    int nb;
    spi_sck = cpol;
    @(negedge clock);
    spi_ss_n = 1'b0;
    repeat (H) @(negedge clock);
    check("miso_oe_on", {7'd0, spi_miso_oe}, 8'd1);
    exp = m_load();
    for (int k = 0; k < nbytes + ((tail > 0) ? 1 : 0); k++) begin
      nb  = (k < nbytes) ? 8 : tail;
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        if (!cpha) begin
          spi_mosi = fr_bytes[k][7-i];
          repeat (H) @(negedge clock);
          spi_sck = ~cpol; got = {got[6:0], spi_miso}; last_sample = cyc;
          repeat (H) @(negedge clock);
          spi_sck = cpol;
        end else begin
          spi_sck = ~cpol; spi_mosi = fr_bytes[k][7-i];
          repeat (H) @(negedge clock);
          spi_sck = cpol; got = {got[6:0], spi_miso}; last_sample = cyc;
          repeat (H) @(negedge clock);
        end
      end
      if (nb == 8) begin
        miso_got[k] = got;
        check("miso_model", got, exp);
        m_push(fr_bytes[k]);
        exp = m_load();
      end
    end
    repeat (H) @(negedge clock);
    spi_ss_n = 1'b1;
    repeat (H) @(negedge clock);
    check("miso_oe_off", {7'd0, spi_miso_oe}, 8'd0);
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [7:0] tx;
    logic [7:0] rx;
    logic [7:0] exp_miso;
    logic [7:0] exp_data;
  } vec_t;

  vec_t       vecs[4];
  logic [7:0] d;

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[2] = '{1'b0, 1'b1, 8'hC3, 8'h96, 8'hC3, 8'h96};
    vecs[3] = '{1'b1, 1'b0, 8'h5E, 8'h81, 8'h5E, 8'h81};

    // Clock/reset
    reset = 1'b1; bus_addr = 8'h00; bus_wdata = 8'h00; bus_io = 1'b0;
    bus_rd = 1'b0; bus_wr = 1'b0; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_rdata", bus_rdata, 8'h00);
    check("rst_irq", {7'd0, irq}, 8'd0);
    check("rst_miso", {7'd0, spi_miso}, 8'd1);
    check("rst_oe", {7'd0, spi_miso_oe}, 8'd0);
    reset = 1'b0;
    @(negedge clock);
    cpu_check_stat("rst_stat");
    bus_read(A_CTRL, 1, d);
    check("rst_ctrl", d, 8'h00);

    // Mode table
    for (int v = 0; v < 4; v++) begin
      cpu_clear(8'hC0);
      cpu_ctrl({2'b00, vecs[v].cpol, vecs[v].cpha, 1'b1});
      spi_sck = vecs[v].cpol;
      repeat (4) @(negedge clock);
      cpu_tx(vecs[v].tx);
      fr_bytes[0] = vecs[v].rx;
      spi_frame(vecs[v].cpol, vecs[v].cpha, 1, 0);
      check("tbl_miso", miso_got[0], vecs[v].exp_miso);
      bus_read(A_STAT, 1, d);
      check("tbl_rxfull_set", {7'd0, d[0]}, 8'd1);
      bus_read(A_DATA, 1, d);
      check("tbl_data", d, vecs[v].exp_data);
      void'(m_rxq.pop_front());
      bus_read(A_STAT, 1, d);
      check("tbl_rxfull_clr", {7'd0, d[0]}, 8'd0);
    end

    // Underrun: no TX write, idle byte goes out, W1C clears it
    cpu_ctrl(5'b00001);
    spi_sck = 1'b0;
    cpu_clear(8'hC0);
    fr_bytes[0] = 8'h5A;
    spi_frame(1'b0, 1'b0, 1, 0);
    check("underrun_miso", miso_got[0], 8'hFF);
    bus_read(A_STAT, 1, d);
    check("underrun_flag", {7'd0, d[6]}, 8'd1);
    cpu_clear(8'h40);
    bus_read(A_STAT, 1, d);
    check("underrun_w1c", {7'd0, d[6]}, 8'd0);
    cpu_read_data("underrun_data", 1);

    // Two bytes left unread
    cpu_tx(8'hE7);
    fr_bytes[0] = 8'h11; fr_bytes[1] = 8'h22;
    spi_frame(1'b0, 1'b0, 2, 0);
    cpu_check_stat("two_stat");
    check("two_ovr_exp", {7'd0, m_ovr}, (RX_DEPTH == 1) ? 8'd1 : 8'd0);
    while (m_rxq.size() != 0) cpu_read_data("two_data", 1);
    cpu_clear(8'hC0);

    // Partial byte aborted by ss_n, then a full byte
    cpu_tx(8'h3A);
    fr_bytes[0] = 8'hD2;
    spi_frame(1'b0, 1'b0, 0, 5);
    cpu_tx(8'h6B);
    fr_bytes[0] = 8'h77;
    spi_frame(1'b0, 1'b0, 1, 0);
    check("abort_miso", miso_got[0], 8'h6B);
    cpu_check_stat("abort_stat");
    bus_read(A_DATA, 1, d);
    check("abort_data", d, 8'h77);
    void'(m_rxq.pop_front());
    cpu_clear(8'hC0);

    // irq latency, clear by read, held read pops once
    cpu_ctrl(5'b01001);
    cpu_tx(8'h0F);
    fr_bytes[0] = 8'h99;
    spi_frame(1'b0, 1'b0, 1, 0);
    check("irq_latency", 8'(irq_rise - last_sample), 8'd5);
    cpu_read_data("irq_data", 1);
    check("irq_still", {7'd0, irq}, 8'd1);
    @(negedge clock);
    check("irq_clear", {7'd0, irq}, 8'd0);
    cpu_clear(8'hC0);
    cpu_tx(8'h81);
    fr_bytes[0] = 8'hAB; fr_bytes[1] = 8'hCD;
    spi_frame(1'b0, 1'b0, 2, 0);
    cpu_read_data("hold_data", 3);
    cpu_check_stat("hold_stat");
    while (m_rxq.size() != 0) cpu_read_data("hold_drain", 1);
    cpu_clear(8'hC0);

    // Random frames against the model
    for (int r = 0; r < 24; r++) begin
      logic cp, ch;
      int   n, nrd;
      cp = 1'($urandom_range(0, 1));
      ch = 1'($urandom_range(0, 1));
      cpu_ctrl({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cp, ch, 1'b1});
      spi_sck = cp;
      repeat (4) @(negedge clock);
      if ($urandom_range(0, 3) != 0) cpu_tx(8'($urandom));
      n = $urandom_range(1, 2);
      for (int k = 0; k < n; k++) fr_bytes[k] = 8'($urandom);
      spi_frame(cp, ch, n, 0);
      check_irq("rnd_irq");
      nrd = $urandom_range(0, m_rxq.size());
      for (int k = 0; k < nrd; k++) cpu_read_data("rnd_data", 1);
      cpu_check_stat("rnd_stat");
      if ($urandom_range(0, 2) == 0) cpu_clear(8'hC0);
      check_irq("rnd_irq2");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
